// File: rtl/cmd_resp_master.sv
// cmd_resp_master: host-side UART command initiator.
// Sends a 16-bit command as two back-to-back 8N1 frames (high byte first),
// then counts response bytes on RX until the opcode's expected count
// (ENTRIES for a dump, otherwise 1) is reached.
// Optional: define CMD_RESP_TIMEOUT_EN to abandon WAIT_RESP after
// TIMEOUT_CYC idle-RX clocks; otherwise timeout is tied low.
module cmd_resp_master #(
  parameter int BAUD_DIV    = 2604,
  parameter int ENTRIES     = 384,
  parameter int LOG2        = 9,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [15:0]     cmd,
  input  logic            snd_cmd,
  output logic            TX,
  input  logic            RX,
  output logic            busy,
  output logic            cmd_cmplt,
  output logic            rdy,
  output logic [7:0]      rx_data,
  input  logic            clr_rdy,
  output logic [LOG2-1:0] resp_cnt,
  output logic            overrun,
  output logic            frm_err,
  output logic            timeout
);

  localparam logic [15:0]   BIT_LAST  = 16'(BAUD_DIV - 1);
  localparam logic [15:0]   HALF_LAST = 16'(BAUD_DIV / 2 - 1);
  // One extra bit so the expected count can equal 2^LOG2
  localparam logic [LOG2:0] DUMP_CNT  = (LOG2+1)'(ENTRIES);
  localparam logic [LOG2:0] ONE_CNT   = (LOG2+1)'(1);

  typedef enum logic [1:0] {IDLE, TX_HI, TX_LO, WAIT_RESP} state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  state_t        state;
  logic [7:0]    cmd_lo;
  logic [LOG2:0] exp_cnt;
  logic [LOG2:0] cnt_nxt;
  logic [15:0]   tx_baud;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  rx_state_t     rx_st;
  logic          rx_s1, rx_s2, rx_prev, rx_fall;
  logic [15:0]   rx_baud;
  logic [2:0]    rx_bits;
  logic [7:0]    rx_sh;
  logic          rx_vld, rx_ferr;

  assign rx_fall = rx_prev & ~rx_s2;
  assign cnt_nxt = {1'b0, resp_cnt} + ONE_CNT;

`ifdef CMD_RESP_TIMEOUT_EN
  localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0] tmo_cnt;
  logic        rx_start;
  assign rx_start = rx_fall && (rx_st == R_IDLE);
`else
  assign timeout = 1'b0;
`endif

  // Two-flop synchronizer plus one delayed copy for falling-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // Receiver: mid-bit sampling, glitch reject on start, one-cycle result pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_st   <= R_IDLE;
      rx_baud <= '0;
      rx_bits <= '0;
      rx_sh   <= '0;
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
    end else begin
      rx_vld  <= 1'b0;
      rx_ferr <= 1'b0;
      case (rx_st)
        R_IDLE: if (rx_fall) begin
          rx_st   <= R_START;
          rx_baud <= '0;
        end
        R_START: begin
          if (rx_baud == HALF_LAST) begin
            rx_baud <= '0;
            rx_bits <= '0;
            rx_st   <= rx_s2 ? R_IDLE : R_DATA;
          end else begin
            rx_baud <= rx_baud + 16'd1;
          end
        end
        R_DATA: begin
          if (rx_baud == BIT_LAST) begin
            rx_baud <= '0;
            rx_sh   <= {rx_s2, rx_sh[7:1]};
            rx_bits <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_st <= R_STOP;
          end else begin
            rx_baud <= rx_baud + 16'd1;
          end
        end
        R_STOP: begin
          if (rx_baud == BIT_LAST) begin
            rx_baud <= '0;
            rx_vld  <= rx_s2;
            rx_ferr <= ~rx_s2;
            rx_st   <= R_IDLE;
          end else begin
            rx_baud <= rx_baud + 16'd1;
          end
        end
        default: rx_st <= R_IDLE;
      endcase
    end
  end

  // Command FSM: transmit both frames, then deliver and count responses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      TX        <= 1'b1;
      busy      <= 1'b0;
      cmd_cmplt <= 1'b0;
      rdy       <= 1'b0;
      rx_data   <= '0;
      resp_cnt  <= '0;
      overrun   <= 1'b0;
      frm_err   <= 1'b0;
      cmd_lo    <= '0;
      exp_cnt   <= '0;
      tx_baud   <= '0;
      tx_bit    <= '0;
      tx_sh     <= '1;
`ifdef CMD_RESP_TIMEOUT_EN
      timeout   <= 1'b0;
      tmo_cnt   <= '0;
`endif
    end else begin
      if (clr_rdy) rdy <= 1'b0;
      if (rx_ferr) frm_err <= 1'b1;
      case (state)
        IDLE: if (snd_cmd) begin
          cmd_lo    <= cmd[7:0];
          exp_cnt   <= (cmd[15:14] == 2'b10) ? DUMP_CNT : ONE_CNT;
          resp_cnt  <= '0;
          cmd_cmplt <= 1'b0;
          overrun   <= 1'b0;
          frm_err   <= 1'b0;
`ifdef CMD_RESP_TIMEOUT_EN
          timeout   <= 1'b0;
`endif
          busy      <= 1'b1;
          TX        <= 1'b0;
          tx_sh     <= {1'b1, cmd[15:8]};
          tx_bit    <= '0;
          tx_baud   <= '0;
          state     <= TX_HI;
        end
        TX_HI, TX_LO: begin
          if (tx_baud == BIT_LAST) begin
            tx_baud <= '0;
            if (tx_bit == 4'd9) begin
              tx_bit <= '0;
              if (state == TX_HI) begin
                // Low byte's start bit follows the stop bit with no gap
                TX    <= 1'b0;
                tx_sh <= {1'b1, cmd_lo};
                state <= TX_LO;
              end else begin
                TX    <= 1'b1;
                state <= WAIT_RESP;
`ifdef CMD_RESP_TIMEOUT_EN
                tmo_cnt <= '0;
`endif
              end
            end else begin
              TX     <= tx_sh[0];
              tx_sh  <= {1'b1, tx_sh[8:1]};
              tx_bit <= tx_bit + 4'd1;
            end
          end else begin
            tx_baud <= tx_baud + 16'd1;
          end
        end
        WAIT_RESP: begin
          if (rx_vld) begin
            resp_cnt <= cnt_nxt[LOG2-1:0];
            // A byte still unacknowledged is kept; the newcomer is lost
            if (rdy && !clr_rdy) begin
              overrun <= 1'b1;
            end else begin
              rx_data <= rx_sh;
              rdy     <= 1'b1;
            end
            if (cnt_nxt == exp_cnt) begin
              cmd_cmplt <= 1'b1;
              busy      <= 1'b0;
              state     <= IDLE;
            end
          end
`ifdef CMD_RESP_TIMEOUT_EN
          if (rx_start) tmo_cnt <= '0;
          else          tmo_cnt <= tmo_cnt + 32'd1;
          if (!rx_vld && tmo_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_resp_master.sv
// Bench for cmd_resp_master: transaction-level model of the outputs,
// per-cycle output compare, per-cycle TX frame check, randomized commands.
module tb_cmd_resp_master;
  localparam int B   = 16;
  localparam int ENT = 384;
  localparam int LG  = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [15:0]   cmd = '0;
  logic          snd_cmd = 1'b0;
  logic          RX = 1'b1;
  logic          clr_rdy = 1'b0;
  logic          TX, busy, cmd_cmplt, rdy, overrun, frm_err, timeout;
  logic [7:0]    rx_data;
  logic [LG-1:0] resp_cnt;

  always #5 clk = ~clk;

  cmd_resp_master #(.BAUD_DIV(B), .ENTRIES(ENT), .LOG2(LG), .TIMEOUT_CYC(5000)) dut (
    .clk(clk), .rst_n(rst_n), .cmd(cmd), .snd_cmd(snd_cmd), .TX(TX), .RX(RX),
    .busy(busy), .cmd_cmplt(cmd_cmplt), .rdy(rdy), .rx_data(rx_data),
    .clr_rdy(clr_rdy), .resp_cnt(resp_cnt), .overrun(overrun),
    .frm_err(frm_err), .timeout(timeout));

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cyc = 0;
  bit chk_en = 1'b0;

  // Model state, one entry per observable output
  bit         m_busy, m_cmplt, m_rdy, m_ovr, m_ferr;
  logic [7:0] m_data;
  int         m_cnt, m_exp;
  logic [19:0] txq[$];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_cmplt = 0; m_rdy = 0; m_ovr = 0; m_ferr = 0;
    m_data = '0; m_cnt = 0; m_exp = 0;
  endtask

  // One-cycle snd_cmd pulse; the model accepts it only when not busy
  task automatic pulse_snd(input logic [15:0] c);
    @(posedge clk); #1;
    cmd = c; snd_cmd = 1'b1;
    @(posedge clk); #1;
    snd_cmd = 1'b0;
    if (!m_busy) begin
      m_busy = 1; m_cmplt = 0; m_ovr = 0; m_ferr = 0; m_cnt = 0;
      m_exp = (c[15:14] == 2'b10) ? ENT : 1;
      txq.push_back({1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0});
      acc_cyc = cyc;
    end
  endtask

  // Both command frames take 20 bit times after acceptance
  task automatic wait_tx_done();
    while (cyc < acc_cyc + 20 * B + 2) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame on RX; good=0 makes the stop bit low
  task automatic send_byte(input logic [7:0] b, input bit good);
    chk_en = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      if (i == 0)      RX = 1'b0;
      else if (i == 9) RX = good;
      else             RX = b[i-1];
      repeat (B) @(posedge clk);
      #1;
    end
    RX = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    if (!good) m_ferr = 1;
    else if (m_busy) begin
      m_cnt++;
      if (m_rdy && !clr_rdy) m_ovr = 1;
      else begin m_data = b; m_rdy = 1; end
      if (m_cnt == m_exp) begin m_cmplt = 1; m_busy = 0; end
    end
    chk_en = 1'b1;
  endtask

  task automatic do_clr();
    @(posedge clk); #1;
    clr_rdy = 1'b1;
    @(posedge clk); #1;
    clr_rdy = 1'b0;
    m_rdy = 0;
  endtask

  task automatic finish_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  endtask

  initial begin
    logic [1:0]  opc;
    logic [15:0] c;
    model_reset();
    fork
      begin : cyc_cnt
        forever begin @(posedge clk); cyc++; end
      end
      begin : out_cmp
        int nprint;
        nprint = 0;
        forever begin
          @(negedge clk);
          if (chk_en && rst_n) begin
            total++;
            if ({busy, cmd_cmplt, rdy, overrun, frm_err, timeout, rx_data, resp_cnt} !==
                {m_busy, m_cmplt, m_rdy, m_ovr, m_ferr, 1'b0, m_data, LG'(m_cnt)}) begin
              bad++;
              if (nprint < 20)
                $display("FAIL outputs cyc=%0d: got busy=%b cmplt=%b rdy=%b ovr=%b ferr=%b tmo=%b data=%h cnt=%0d want busy=%b cmplt=%b rdy=%b ovr=%b ferr=%b tmo=0 data=%h cnt=%0d",
                         cyc, busy, cmd_cmplt, rdy, overrun, frm_err, timeout, rx_data, resp_cnt,
                         m_busy, m_cmplt, m_rdy, m_ovr, m_ferr, m_data, m_cnt);
              nprint++;
            end
          end
        end
      end
      begin : tx_mon
        bit          act;
        int          mc, nbad;
        logic [19:0] fr;
        act = 0; mc = 0; nbad = 0; fr = '1;
        forever begin
          @(negedge clk);
          if (!rst_n) act = 0;
          else begin
            if (!act && TX === 1'b0) begin
              // A start bit with nothing queued is checked against an idle line
              fr = (txq.size() != 0) ? txq.pop_front() : 20'hFFFFF;
              act = 1; mc = 0; nbad = 0;
            end
            if (act) begin
              if (TX !== fr[mc / B]) nbad++;
              mc++;
              if (mc == 20 * B) begin
                act = 0;
                total++;
                if (nbad != 0) begin
                  bad++;
                  $display("FAIL tx_frame: got %0d wrong bit-cycles want 0 (frame %05h)", nbad, fr);
                end
              end
            end
          end
        end
      end
      begin : watchdog
        repeat (98000) @(posedge clk);
        total++; bad++;
        $display("FAIL watchdog: got no finish want finish before cycle 98000");
        finish_run();
      end
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tx", TX, 1);         chk("rst_busy", busy, 0);
    chk("rst_cmplt", cmd_cmplt, 0); chk("rst_rdy", rdy, 0);
    chk("rst_data", rx_data, 0);  chk("rst_cnt", resp_cnt, 0);
    chk("rst_ovr", overrun, 0);   chk("rst_ferr", frm_err, 0);
    chk("rst_tmo", timeout, 0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Write
    pulse_snd(16'h4BAF);
    chk("wr_busy_rise", busy, 1);
    wait_tx_done();
    send_byte(8'hA5, 1);
    chk("wr_rdy", rdy, 1);          chk("wr_data", rx_data, 8'hA5);
    chk("wr_cnt", resp_cnt, 1);     chk("wr_cmplt", cmd_cmplt, 1);
    chk("wr_busy", busy, 0);
    do_clr();
    chk("clr_rdy", rdy, 0);

    // Read, then a new command clears cmd_cmplt
    pulse_snd(16'h0B00);
    wait_tx_done();
    send_byte(8'hAF, 1);
    chk("rd_data", rx_data, 8'hAF); chk("rd_cmplt", cmd_cmplt, 1);
    do_clr();
    pulse_snd(16'h0B00);
    chk("rd_cmplt_clr", cmd_cmplt, 0);
    chk("rd_cnt_clr", resp_cnt, 0);
    wait_tx_done();
    send_byte(8'h3C, 1);
    do_clr();

    // Overrun: second byte lands while the first is unacknowledged
    pulse_snd(16'h4001);
    wait_tx_done();
    send_byte(8'h11, 1);
    pulse_snd(16'h0000);
    wait_tx_done();
    send_byte(8'h22, 1);
    chk("ovr_flag", overrun, 1);    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_cnt", resp_cnt, 1);    chk("ovr_cmplt", cmd_cmplt, 1);
    do_clr();

    // Framing error: bad frame is not counted
    pulse_snd(16'h0B00);
    wait_tx_done();
    send_byte(8'h5A, 0);
    chk("ferr_flag", frm_err, 1);   chk("ferr_cnt", resp_cnt, 0);
    chk("ferr_busy", busy, 1);
    send_byte(8'h77, 1);
    chk("ferr_done", cmd_cmplt, 1); chk("ferr_data", rx_data, 8'h77);
    do_clr();

    // snd_cmd while busy is ignored
    pulse_snd(16'h1357);
    repeat (3 * B) @(posedge clk);
    pulse_snd(16'hC0DE);
    wait_tx_done();
    send_byte(8'h99, 1);
    chk("ign_data", rx_data, 8'h99);
    do_clr();

    // A byte while idle is discarded
    send_byte(8'hE7, 1);
    chk("idle_cnt", resp_cnt, 1);   chk("idle_data", rx_data, 8'h99);
    chk("idle_rdy", rdy, 0);

    // Randomized single-response commands
    for (int n = 0; n < 10; n++) begin
      case ($urandom_range(0, 2))
        0:       opc = 2'b00;
        1:       opc = 2'b01;
        default: opc = 2'b11;
      endcase
      c = {opc, 14'($urandom)};
      pulse_snd(c);
      wait_tx_done();
      send_byte(8'($urandom), $urandom_range(0, 3) != 0);
      for (int k = 0; k < 3 && m_busy; k++) send_byte(8'($urandom), 1);
      if ($urandom_range(0, 1) == 1) do_clr();
      if ($urandom_range(0, 3) == 0) send_byte(8'($urandom), 1);
    end

    // Dump: 384 bytes valued (k+1) mod 256
    do_clr();
    pulse_snd(16'h8100);
    wait_tx_done();
    for (int k = 0; k < ENT; k++) begin
      send_byte(8'((k + 1) % 256), 1);
      chk("dump_data", rx_data, (k + 1) % 256);
      if (k < ENT - 1) do_clr();
    end
    chk("dump_cnt", resp_cnt, ENT);  chk("dump_cmplt", cmd_cmplt, 1);
    chk("dump_ovr", overrun, 0);     chk("dump_busy", busy, 0);

    // Async reset in the middle of the low-byte frame
    pulse_snd(16'h4321);
    while (cyc < acc_cyc + 14 * B) @(posedge clk);
    chk_en = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_tx", TX, 1);          chk("arst_busy", busy, 0);
    chk("arst_cmplt", cmd_cmplt, 0); chk("arst_rdy", rdy, 0);
    chk("arst_data", rx_data, 0);   chk("arst_cnt", resp_cnt, 0);
    chk("arst_ovr", overrun, 0);    chk("arst_ferr", frm_err, 0);
    model_reset();
    txq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4 * B) @(posedge clk);

    // Recovery after reset
    pulse_snd(16'h4BAF);
    wait_tx_done();
    send_byte(8'h5A, 1);
    chk("rec_data", rx_data, 8'h5A); chk("rec_cmplt", cmd_cmplt, 1);
    repeat (4) @(posedge clk);

    finish_run();
  end
endmodule

// File: doc/cmd_resp_master.md
Name: cmd_resp_master

Overview:
- Host-side initiator for the analyzer's UART command protocol.
- Serializes a 16-bit command onto TX as two 8N1 bytes, high byte first, then collects the responses the command-config block returns on RX.
- Knows from the opcode how many response bytes to expect:
  - read, write and reserved: 1 byte;
  - dump: ENTRIES bytes.
- Raises cmd_cmplt when the expected response count is reached. Used as the bench/host master and for board-level loopback.

Parameters:
- BAUD_DIV, 2604: clocks per UART bit; legal range 16..65535.
- ENTRIES, 384: bytes returned by a dump command.
- LOG2, 9: width of the response counter; 2^LOG2 >= ENTRIES.
- TIMEOUT_CYC, 1000000: idle-RX clocks before timeout (feature only).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cmd  in  16  command; [15:14] opcode (00 rd, 01 wr, 10 dump, 11 rsvd)
- snd_cmd  in  1  one-cycle strobe; latch cmd and start
- TX  out  1  UART serial out, idle high
- RX  in  1  UART serial in, asynchronous
- busy  out  1  high from snd_cmd accept until return to IDLE
- cmd_cmplt  out  1  sticky; set when all expected bytes received, cleared on next accepted snd_cmd
- rdy  out  1  a response byte is valid in rx_data
- rx_data  out  8  last received response byte
- clr_rdy  in  1  consumer acknowledges rx_data
- resp_cnt  out  LOG2  response bytes received for current command
- overrun  out  1  sticky; a byte arrived while rdy=1 and clr_rdy=0
- frm_err  out  1  sticky; stop bit sampled low
- timeout  out  1  sticky; see Optional Feature (tied 0 when absent)

Behaviour:
- Reset values: TX=1. busy, cmd_cmplt, rdy, overrun, frm_err and timeout all 0. rx_data=0, resp_cnt=0. FSM in IDLE.
- Sticky flags (cmd_cmplt, overrun, frm_err, timeout) clear on the next accepted snd_cmd.
- FSM states: IDLE, TX_HI, TX_LO, WAIT_RESP.
  - IDLE: snd_cmd=1 latches cmd, loads expected count (ENTRIES if opcode 10, else 1), zeroes resp_cnt and clears sticky flags. Next state TX_HI; busy rises the following cycle.
  - TX_HI: transmit cmd[15:8]. On the tx-done pulse go to TX_LO.
  - TX_LO: transmit cmd[7:0]. On tx-done go to WAIT_RESP.
  - WAIT_RESP: each valid received byte increments resp_cnt. When resp_cnt reaches the expected count, set cmd_cmplt and go to IDLE in the same cycle.
- snd_cmd while busy: ignored; no state or flag change.
- TX framing:
  - 10 bits, LSB first: start 0, 8 data, stop 1; each bit held exactly BAUD_DIV clocks.
  - One frame is 10*BAUD_DIV clocks.
  - TX_LO's start bit begins the cycle after TX_HI's stop bit ends, with no idle gap.
- RX datapath:
  - Double-flop synchronizer on RX.
  - Start detected on a synchronized falling edge while the receiver is idle.
  - Re-check the line at BAUD_DIV/2: if high, treat as a glitch and return to idle with no byte.
  - Sample the 8 data bits at mid-bit (every BAUD_DIV), LSB first, then sample the stop bit.
  - Stop bit low: set frm_err, discard the byte, no count.
  - The receiver is active in all FSM states. Bytes arriving outside WAIT_RESP are discarded and do not count.
- Byte delivery:
  - A valid byte in WAIT_RESP loads rx_data and sets rdy one clock after the stop-bit sample.
  - clr_rdy clears rdy the next clock.
  - If a byte lands while rdy=1 and clr_rdy=0: set overrun, keep the old rx_data, but still increment resp_cnt.
  - New byte and clr_rdy in the same cycle: the new byte wins; rdy stays 1 and rx_data is updated.
- resp_cnt does not wrap: the FSM leaves WAIT_RESP at exactly the expected count, so the maximum is ENTRIES.
- Async reset mid-frame: TX returns high immediately and all state returns to reset values. Any partial RX frame is dropped.

Optional Feature:
- Macro: CMD_RESP_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_RESP and clears on every RX start-bit detect.
  - Reaching TIMEOUT_CYC sets timeout, deasserts busy and returns to IDLE without setting cmd_cmplt.
- Undefined: no counter exists, timeout is constant 0, and WAIT_RESP waits indefinitely.

Test Plan:
- Write: cmd=16'h4BAF, snd_cmd pulse. TX must show bytes 0x4B then 0xAF, each 10*BAUD_DIV clocks. Responder returns 0xA5 -> rdy=1, rx_data=8'hA5, resp_cnt=1, cmd_cmplt=1, busy=0.
- Read: cmd=16'h0B00, responder returns 0xAF -> rx_data=8'hAF, cmd_cmplt=1. Then a second snd_cmd clears cmd_cmplt.
- Dump: cmd=16'h8100, responder streams 384 bytes valued (k+1) mod 256. The bench pulses clr_rdy after each -> each rx_data matches, resp_cnt=384, cmd_cmplt set once, overrun=0.
- Overrun and errors:
  - Withhold clr_rdy across two response bytes 0x11, 0x22 -> overrun=1 and rx_data stays 0x11.
  - A frame with stop bit 0 -> frm_err=1 and resp_cnt unchanged.
- Busy and reset:
  - snd_cmd during TX_HI with a different cmd -> ignored; the TX bytes are still from the first cmd.
  - rst_n low mid-TX_LO -> TX=1 and all outputs at reset values within the same cycle.
- With CMD_RESP_TIMEOUT_EN and TIMEOUT_CYC=5000: send 16'h0B00 with no response -> timeout=1 and busy=0 after 5000 clocks in WAIT_RESP, cmd_cmplt=0.
